// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: bit-serial double-dabble binary to BCD converter
// with valid/ready handshakes, optional signed input and overflow flag.
module bin2bcd_seq #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5,
  parameter int SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      in_bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_neg,
  output logic                  out_ovf
);

  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + BIN_W;
  localparam int CW = (BIN_W > 2) ? $clog2(BIN_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIN_W - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [SW-1:0]    sr;
  logic [SW-1:0]    adj;
  logic [SW-1:0]    shf;
  logic             msb;
  logic             neg_r;
  logic             ovf_r;
  logic             neg_in;
  logic [BIN_W-1:0] mag;

  assign in_ready = (state == IDLE);
  assign neg_in   = (SIGNED != 0) && in_bin[BIN_W-1];
  assign mag      = neg_in ? (~in_bin + BIN_W'(1)) : in_bin;

  // Digits are corrected independently; a BCD digit never exceeds 12 here.
  always_comb begin
    adj = sr;
    for (int k = 0; k < DIGITS; k++) begin
      if (sr[BIN_W+4*k +: 4] > 4'd4)
        adj[BIN_W+4*k +: 4] = sr[BIN_W+4*k +: 4] + 4'd3;
    end
  end

  assign shf = {adj[SW-2:0], 1'b0};
  assign msb = adj[SW-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      sr        <= '0;
      neg_r     <= 1'b0;
      ovf_r     <= 1'b0;
      out_valid <= 1'b0;
      out_bcd   <= '0;
      out_neg   <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sr    <= {{BW{1'b0}}, mag};
            neg_r <= neg_in;
            ovf_r <= 1'b0;
            cnt   <= '0;
            state <= CONV;
          end
        end
        CONV: begin
          sr    <= shf;
          ovf_r <= ovf_r | msb;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            out_bcd   <= shf[SW-1:BIN_W];
            out_neg   <= neg_r;
            out_ovf   <= ovf_r | msb;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed and random checks of bin2bcd_seq
// across several width/digit/sign configurations.
module tb_bin2bcd_seq;

  typedef struct packed {
    longint bcd;
    logic   neg;
    logic   ovf;
  } exp_t;

  function automatic int bw(input int g);
    case (g)
      0, 1, 2: return 16;
      3, 4:    return 8;
      default: return 20;
    endcase
  endfunction

  function automatic int dg(input int g);
    case (g)
      0, 1:    return 5;
      2:       return 4;
      3:       return 2;
      4:       return 3;
      5:       return 6;
      default: return 7;
    endcase
  endfunction

  function automatic int sg(input int g);
    return (g == 1 || g == 4 || g == 6) ? 1 : 0;
  endfunction

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] bin = '0;
  logic        iv [7];
  logic        ordy [7];
  logic        ir [7];
  logic        ov [7];
  logic        ng [7];
  logic        of [7];
  logic [27:0] obcd [7];

  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;
  int   last_v = 0;
  exp_t sbq [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 7; g++) begin : g_dut
    localparam int B = bw(g);
    localparam int D = dg(g);
    logic [4*D-1:0] bcd;
    bin2bcd_seq #(.BIN_W(B), .DIGITS(D), .SIGNED(sg(g))) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv[g]),
      .in_ready  (ir[g]),
      .in_bin    (bin[B-1:0]),
      .out_valid (ov[g]),
      .out_ready (ordy[g]),
      .out_bcd   (bcd),
      .out_neg   (ng[g]),
      .out_ovf   (of[g])
    );
    assign obcd[g] = 28'(bcd);
  end

  function automatic exp_t model(input int id, input longint v);
    exp_t   e;
    longint m;
    longint lim;
    int     b;
    b = bw(id);
    m = v & ((64'd1 << b) - 1);
    e.neg = 1'b0;
    e.bcd = 0;
    if (sg(id) != 0 && ((m >> (b - 1)) & 1) == 1) begin
      m = (64'd1 << b) - m;
      e.neg = 1'b1;
    end
    lim = 1;
    for (int k = 0; k < dg(id); k++) lim = lim * 10;
    e.ovf = (m >= lim);
    for (int k = 0; k < dg(id); k++) begin
      e.bcd = e.bcd | ((m % 10) << (4 * k));
      m = m / 10;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input int id, input longint v, input bit gap);
    exp_t e;
    int   ca;
    int   n;
    sbq.push_back(model(id, v));
    @(negedge clk);
    bin = 32'(v);
    iv[id] = 1'b1;
    ordy[id] = 1'b1;
    n = 0;
    while (!ir[id] && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    iv[id] = 1'b0;
    ca = cyc;
    n = 0;
    while (!ov[id] && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk($sformatf("lat%0d", id), cyc - ca, bw(id));
    if (gap) chk($sformatf("gap%0d", id), cyc - last_v, bw(id) + 2);
    last_v = cyc;
    e = sbq.pop_front();
    chk($sformatf("bcd%0d_%0h", id, v), obcd[id], e.bcd);
    chk($sformatf("neg%0d_%0h", id, v), ng[id], e.neg);
    chk($sformatf("ovf%0d_%0h", id, v), of[id], e.ovf);
  endtask

  initial begin
    exp_t e;
    int   ca;
    int   n;
    for (int i = 0; i < 7; i++) begin
      iv[i] = 1'b0;
      ordy[i] = 1'b0;
    end

    repeat (3) @(negedge clk);
    chk("rst_ir", ir[0], 1);
    chk("rst_ov", ov[0], 0);
    chk("rst_bcd", obcd[0], 0);
    chk("rst_neg", ng[1], 0);
    chk("rst_ovf", of[2], 0);
    rst_n = 1'b1;

    run(0, 64'hFFFF, 0);
    chk("ffff_lit", obcd[0], 28'h65535);
    run(0, 0, 0);
    run(1, 64'h8000, 0);
    chk("s8000_lit", obcd[1], 28'h32768);
    run(1, 64'hFFFF, 0);
    run(1, 0, 0);
    run(2, 9999, 0);
    run(2, 10000, 0);

    // backpressure: result held while out_ready low
    sbq.push_back(model(0, 64'hFFFF));
    @(negedge clk);
    bin = 32'hFFFF;
    iv[0] = 1'b1;
    ordy[0] = 1'b0;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    ca = cyc;
    n = 0;
    while (!ov[0] && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_lat", cyc - ca, 16);
    e = sbq.pop_front();
    chk("bp_bcd", obcd[0], e.bcd);
    bin = 32'd5;
    iv[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_ov", ov[0], 1);
      chk("bp_hold", obcd[0], e.bcd);
      chk("bp_ir", ir[0], 0);
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    @(negedge clk);
    ordy[0] = 1'b0;
    chk("bp_ov_clr", ov[0], 0);
    chk("bp_ir_set", ir[0], 1);

    // asynchronous reset mid-conversion
    @(negedge clk);
    bin = 32'hFFFF;
    iv[0] = 1'b1;
    ordy[0] = 1'b1;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_ov", ov[0], 0);
    chk("ar_bcd", obcd[0], 0);
    chk("ar_ir", ir[0], 1);
    chk("ar_bcd1", obcd[1], 0);
    chk("ar_neg1", ng[1], 0);
    chk("ar_ovf2", of[2], 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(0, 1234, 0);
    chk("ar_1234", obcd[0], 28'h01234);

    // random sweep with back-to-back requests
    for (int id = 0; id < 7; id++) begin
      if (id == 2) continue;
      for (int i = 0; i < 8; i++)
        run(id, longint'($urandom), i > 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
